// File: rtl/bcd_scan_display.sv
// Multiplexed four-digit BCD scanner driving a common-anode
// seven-segment display, with leading-zero blanking.
module bcd_scan_display #(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ce,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        ld,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dot,
    output logic        frm
);

    localparam logic [15:0] LASTCNT = 16'(DIV - 1);
    localparam logic [1:0]  LAST    = 2'(NDIG - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [1:0]  shown;
    logic        live;
    logic [15:0] sd;
    logic [3:0]  sdp;

    logic [3:0]  cur;
    logic [15:0] hi;
    logic        blank;
    logic [6:0]  segn;

    always_comb begin
        cur   = sd[{idx, 2'b00} +: 4];
        hi    = sd >> {idx, 2'b00};
        blank = blank_lz && (idx != 2'd0) && (hi == 16'd0);
        unique case (cur)
            4'd0:    segn = 7'h40;
            4'd1:    segn = 7'h79;
            4'd2:    segn = 7'h24;
            4'd3:    segn = 7'h30;
            4'd4:    segn = 7'h19;
            4'd5:    segn = 7'h12;
            4'd6:    segn = 7'h02;
            4'd7:    segn = 7'h78;
            4'd8:    segn = 7'h00;
            4'd9:    segn = 7'h10;
            default: segn = 7'h3F;
        endcase
        if (blank)
            segn = 7'h7F;
    end

    // Outputs are built from pre-edge index and shadow, so a load on
    // the advance edge first appears on the following update.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt   <= 16'd0;
            idx   <= 2'd0;
            shown <= 2'd0;
            live  <= 1'b0;
            sd    <= 16'd0;
            sdp   <= 4'd0;
            seg   <= 7'h7F;
            an    <= 4'hF;
            dot   <= 1'b1;
            frm   <= 1'b0;
        end else begin
            if (ld) begin
                sd  <= digits;
                sdp <= dp;
            end
            if (ce) begin
                if (cnt == LASTCNT) begin
                    cnt <= 16'd0;
                    idx <= (idx == LAST) ? 2'd0 : idx + 2'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            seg   <= segn;
            an    <= ~(4'b0001 << idx);
            dot   <= ~sdp[idx];
            frm   <= live && (shown == LAST) && (idx == 2'd0);
            shown <= idx;
            live  <= 1'b1;
        end
    end

endmodule
